// File: rtl/fft_inplace_seq_if.sv
// Sequencer <-> butterfly datapath bundle: issue addresses, write-back addresses, saturation stats.
// master = sequencer side, slave = datapath/frame controller side.
interface fft_inplace_seq_if #(
  parameter int N_LOG2 = 4,
  parameter int CNT_W  = 16
);
  localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;

  logic              start;
  logic              busy;
  logic              done;
  logic              bf_valid;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw_idx;
  logic [SW-1:0]     stage;
  logic              wb_valid;
  logic [N_LOG2-1:0] wb_addr_a;
  logic [N_LOG2-1:0] wb_addr_b;
  logic              sat_in;
  logic [CNT_W-1:0]  sat_cnt;
  logic [N_LOG2-1:0] sat_stage_mask;

  modport master (
    input  start, sat_in,
    output busy, done, bf_valid, addr_a, addr_b, tw_idx, stage,
           wb_valid, wb_addr_a, wb_addr_b, sat_cnt, sat_stage_mask
  );

  modport slave (
    output start, sat_in,
    input  busy, done, bf_valid, addr_a, addr_b, tw_idx, stage,
           wb_valid, wb_addr_a, wb_addr_b, sat_cnt, sat_stage_mask
  );
endinterface

// File: rtl/fft_inplace_seq.sv
// In-place radix-2 DIT FFT stage/butterfly sequencer: one butterfly per cycle, write-back BF_LAT cycles later.
// No backpressure: each stage drains BF_LAT cycles so the next stage never reads unwritten data.
module fft_inplace_seq #(
  parameter int N_LOG2 = 4,
  parameter int BF_LAT = 3,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  fft_inplace_seq_if.master bus
);
  localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam int KW = N_LOG2 - 1;
  localparam int DW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_LOG2-1:0] mask_q, mask_d;

  logic              issue;
  logic [KW-1:0]     lo_mask, lo_k;
  logic [N_LOG2-1:0] k_ext, half, a_raw;
  logic [SW-1:0]     tw_sh;
  logic [N_LOG2-1:0] addr_a, addr_b;

  logic [BF_LAT-1:0] dv_q;
  logic [N_LOG2-1:0] da_q [BF_LAT];
  logic [N_LOG2-1:0] db_q [BF_LAT];
  logic [SW-1:0]     ds_q [BF_LAT];
  logic              wb_vld;
  logic [SW-1:0]     wb_stage;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == {KW{1'b1}}) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(BF_LAT - 1)) begin
          if (stage_q == SW'(N_LOG2 - 1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Upper leg: k with a zero inserted at bit 'stage'; the bits below it also pick the twiddle.
  always_comb begin
    issue   = (state_q == S_ISSUE);
    k_ext   = {1'b0, k_q};
    half    = N_LOG2'(1) << stage_q;
    lo_mask = ~({KW{1'b1}} << stage_q);
    lo_k    = k_q & lo_mask;
    a_raw   = (((k_ext >> stage_q) << 1) << stage_q) | {1'b0, lo_k};
    tw_sh   = SW'(N_LOG2 - 1) - stage_q;
    addr_a  = issue ? a_raw : '0;
    addr_b  = issue ? (a_raw + half) : '0;
  end

  assign wb_vld   = dv_q[BF_LAT-1];
  assign wb_stage = ds_q[BF_LAT-1];

  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (state_q == S_IDLE && bus.start) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (wb_vld && bus.sat_in) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      mask_d[wb_stage] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
        ds_q[i] <= '0;
      end
    end else begin
      dv_q[0] <= issue;
      da_q[0] <= addr_a;
      db_q[0] <= addr_b;
      ds_q[0] <= stage_q;
      for (int i = 1; i < BF_LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        da_q[i] <= da_q[i-1];
        db_q[i] <= db_q[i-1];
        ds_q[i] <= ds_q[i-1];
      end
    end
  end

  assign bus.busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done           = (state_q == S_FIN);
  assign bus.bf_valid       = issue;
  assign bus.addr_a         = addr_a;
  assign bus.addr_b         = addr_b;
  assign bus.tw_idx         = issue ? (lo_k << tw_sh) : '0;
  assign bus.stage          = stage_q;
  assign bus.wb_valid       = wb_vld;
  assign bus.wb_addr_a      = da_q[BF_LAT-1];
  assign bus.wb_addr_b      = db_q[BF_LAT-1];
  assign bus.sat_cnt        = cnt_q;
  assign bus.sat_stage_mask = mask_q;
endmodule

// File: doc/fft_inplace_seq.md
Name: fft_inplace_seq

Overview:
Stage/butterfly sequencer for the in-place radix-2 DIT FFT datapath.
- Issues one butterfly read-address pair per cycle, with its twiddle index.
- Tracks the butterfly pipeline latency and generates the matching write-back addresses.
- Drains the pipeline between stages so stage s+1 never reads unwritten data.
- Collects the overflow flag from the 17-to-16-bit saturation stage into per-frame statistics.

Parameters:
- N_LOG2, 4, log2 of FFT length N (N = 2^N_LOG2; 16-point default).
- BF_LAT, 3, cycles from butterfly issue (bf_valid) to write-back (wb_valid); range 1..15.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- busy  out  1  high while a frame is being sequenced
- done  out  1  one-cycle pulse at frame end
- bf_valid  out  1  butterfly issue strobe
- addr_a  out  N_LOG2  upper-leg read address
- addr_b  out  N_LOG2  lower-leg read address
- tw_idx  out  N_LOG2-1  twiddle ROM index
- stage  out  clog2(N_LOG2)  current stage number, 0..N_LOG2-1
- wb_valid  out  1  write-back strobe, equal to bf_valid delayed by BF_LAT cycles
- wb_addr_a  out  N_LOG2  addr_a delayed by BF_LAT cycles
- wb_addr_b  out  N_LOG2  addr_b delayed by BF_LAT cycles
- sat_in  in  1  saturation flag from the write-back path; valid only with wb_valid
- sat_cnt  out  CNT_W  saturation events in the current/last frame
- sat_stage_mask  out  N_LOG2  bit s set if any saturation occurred in stage s

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Delay line is cleared.
  - Assertion mid-frame aborts the frame immediately; no done pulse.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On start=1 at a clock edge, go to ISSUE.
  - On that same edge: clear sat_cnt and sat_stage_mask, set stage=0 and k=0.
  - start is ignored in every other state.
- ISSUE:
  - bf_valid=1 every cycle; busy=1.
  - Address generation for butterfly k = 0..N/2-1, with half = 2^stage:
    - addr_a = ((k >> stage) << (stage+1)) | (k & (half-1))
    - addr_b = addr_a + half
    - tw_idx = (k & (half-1)) << (N_LOG2-1-stage)
  - Exit when k = N/2-1: go to DRAIN and reset the drain counter to 0.
- DRAIN:
  - bf_valid=0, busy=1, for exactly BF_LAT cycles.
  - Then, if stage < N_LOG2-1: stage++, k=0, go to ISSUE.
  - Otherwise go to FIN.
- FIN:
  - busy=0, done=1 for one cycle, then go to IDLE.
  - stage returns to 0 in IDLE.
- Timing:
  - busy is high for exactly N_LOG2*(N/2+BF_LAT) cycles.
  - The first bf_valid is the first busy cycle.
  - done is in the first cycle after busy falls.
  - Default configuration: 44 busy cycles.
- Write-back delay line:
  - BF_LAT-deep shift register of {bf_valid, addr_a, addr_b} plus the issuing stage number.
  - The last wb_valid of a stage occurs in that stage's final DRAIN cycle, so no write-back overlaps the next stage's reads.
- Saturation statistics:
  - sat_in is sampled only when wb_valid=1.
  - Each sample with sat_in=1 increments sat_cnt; the counter saturates at 2^CNT_W-1 and does not wrap.
  - The same event sets sat_stage_mask[wb_stage].
  - sat_in with wb_valid=0 is ignored.
  - Values hold after done until the next accepted start.
- Simultaneous events: start asserted in the FIN cycle is ignored. A new frame can begin at the earliest on the cycle after done.

Test Plan:
- Reset then a single start pulse, N_LOG2=4, BF_LAT=3 ->
  - busy high for 44 cycles, done pulses once in cycle 45;
  - 32 bf_valid and 32 wb_valid strobes;
  - bf_valid low for 3 cycles between stages.
- Address check, default configuration ->
  - stage0, k=1: addr_a=2, addr_b=3, tw_idx=0;
  - stage2, k=5: addr_a=9, addr_b=13, tw_idx=2;
  - stage3, k=5: addr_a=5, addr_b=13, tw_idx=5;
  - every address 0..15 read exactly once per stage.
- sat_in=1 forced on 3 write-backs in stage 1 and 1 in stage 3, plus sat_in=1 while wb_valid=0 ->
  - sat_cnt=4, sat_stage_mask=4'b1010.
- start held high throughout the frame ->
  - no restart until IDLE;
  - the next frame starts the cycle after done, and sat_cnt is cleared at that start.
- rst_n pulled low mid-stage 2 ->
  - all outputs 0 asynchronously, no done pulse;
  - after release, a new start runs a full, correct frame.
- CNT_W=2 with saturation on every write-back -> sat_cnt sticks at 3.
